// File: rtl/round_sequencer.sv
// round_sequencer: game-round controller.
//   Turns raw win/lose/start levels into single debounced events, sequences
//   PLAY -> banner holds -> level progression -> game over, and owns the
//   level / lives / win tallies shown on the HUD.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, win_in, lose_in level inputs; each rising edge is one event
//   round_active          high only while playing (gates object motion)
//   level, level_wins, total_wins, lives   HUD counters
//   level_up              one-cycle pulse on entry to the level-up banner
//   banner                00 none, 01 win, 10 lose, 11 level-up
//   game_over, victory    end-of-game status
module round_sequencer #(
  parameter int WINS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 15,
  parameter int START_LIVES    = 3,
  parameter int HOLD_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       win_in,
  input  logic       lose_in,
  output logic       round_active,
  output logic [3:0] level,
  output logic [7:0] level_wins,
  output logic [7:0] total_wins,
  output logic [2:0] lives,
  output logic       level_up,
  output logic [1:0] banner,
  output logic       game_over,
  output logic       victory
);

  localparam int TW = $clog2(HOLD_CYCLES);

  typedef enum logic [2:0] {IDLE, PLAY, WIN_HOLD, LOSE_HOLD, LEVEL, OVER} state_t;

  state_t     state, state_nx;
  logic [2:0] in_q, in_prev;     // {start, win_in, lose_in}
  logic       start_ev, win_ev, lose_ev;
  logic [TW-1:0] timer, timer_nx;
  logic       hold_done;
  logic [3:0] level_nx;
  logic [7:0] level_wins_nx, total_wins_nx, wins_inc;
  logic [2:0] lives_nx;
  logic       victory_nx;

  // Inputs are registered once; an event is the first cycle the registered
  // copy is high, so a held level produces exactly one event.
  assign start_ev = in_q[2] & ~in_prev[2];
  assign win_ev   = in_q[1] & ~in_prev[1];
  assign lose_ev  = in_q[0] & ~in_prev[0];

  assign hold_done = (timer == TW'(HOLD_CYCLES - 1));
  assign wins_inc  = level_wins + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_q       <= '0;
      in_prev    <= '0;
      timer      <= '0;
      level      <= '0;
      level_wins <= '0;
      total_wins <= '0;
      lives      <= '0;
      victory    <= 1'b0;
    end else begin
      state      <= state_nx;
      in_q       <= {start, win_in, lose_in};
      in_prev    <= in_q;
      timer      <= timer_nx;
      level      <= level_nx;
      level_wins <= level_wins_nx;
      total_wins <= total_wins_nx;
      lives      <= lives_nx;
      victory    <= victory_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = '0;          // timer is cleared whenever it is not counting
    level_nx      = level;
    level_wins_nx = level_wins;
    total_wins_nx = total_wins;
    lives_nx      = lives;
    victory_nx    = victory;
    case (state)
      IDLE, OVER: begin
        if (start_ev) begin
          state_nx      = PLAY;
          level_nx      = 4'd1;
          level_wins_nx = '0;
          total_wins_nx = '0;
          lives_nx      = 3'(START_LIVES);
          victory_nx    = 1'b0;
        end
      end
      PLAY: begin
        // win has priority; a simultaneous lose is dropped
        if (win_ev) begin
          total_wins_nx = (total_wins == 8'hFF) ? 8'hFF : total_wins + 8'd1;
          if (wins_inc == 8'(WINS_PER_LEVEL)) begin
            state_nx      = LEVEL;
            level_wins_nx = '0;
          end else begin
            state_nx      = WIN_HOLD;
            level_wins_nx = wins_inc;
          end
        end else if (lose_ev) begin
          lives_nx = lives - 3'd1;
          if (lives == 3'd1) begin
            state_nx   = OVER;
            victory_nx = 1'b0;
          end else begin
            state_nx = LOSE_HOLD;
          end
        end
      end
      WIN_HOLD, LOSE_HOLD: begin
        if (hold_done) state_nx = PLAY;
        else           timer_nx = timer + TW'(1);
      end
      LEVEL: begin
        // clearing the last level ends the game right after the entry cycle
        if (level == 4'(MAX_LEVEL)) begin
          state_nx   = OVER;
          victory_nx = 1'b1;
        end else if (hold_done) begin
          state_nx = PLAY;
          level_nx = level + 4'd1;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // LEVEL is always entered with the timer at zero, so timer==0 marks entry.
  assign level_up     = (state == LEVEL) && (timer == '0);
  assign round_active = (state == PLAY);
  assign game_over    = (state == OVER);

  always_comb begin
    banner = 2'b00;
    case (state)
      WIN_HOLD:  banner = 2'b01;
      LOSE_HOLD: banner = 2'b10;
      LEVEL:     banner = 2'b11;
      default:   banner = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: two instances (default game, and a short
// one-level game) driven from one sequence; expected HUD snapshots are
// queued when an event is driven and compared when the DUT reacts.
module tb_round_sequencer;

  localparam int H = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       start [2];
  logic       win   [2];
  logic       lose  [2];
  logic       ra    [2];
  logic [3:0] lvl   [2];
  logic [7:0] lw    [2];
  logic [7:0] tw    [2];
  logic [2:0] lives [2];
  logic       lu    [2];
  logic [1:0] ban   [2];
  logic       go    [2];
  logic       vic   [2];

  round_sequencer #(.WINS_PER_LEVEL(5), .MAX_LEVEL(15), .START_LIVES(3), .HOLD_CYCLES(H)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .win_in(win[0]), .lose_in(lose[0]),
    .round_active(ra[0]), .level(lvl[0]), .level_wins(lw[0]), .total_wins(tw[0]),
    .lives(lives[0]), .level_up(lu[0]), .banner(ban[0]), .game_over(go[0]), .victory(vic[0]));

  round_sequencer #(.WINS_PER_LEVEL(2), .MAX_LEVEL(1), .START_LIVES(3), .HOLD_CYCLES(H)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .win_in(win[1]), .lose_in(lose[1]),
    .round_active(ra[1]), .level(lvl[1]), .level_wins(lw[1]), .total_wins(tw[1]),
    .lives(lives[1]), .level_up(lu[1]), .banner(ban[1]), .game_over(go[1]), .victory(vic[1]));

  typedef struct {
    string      tag;
    int         d;
    logic [3:0] lvl;
    logic [7:0] lw, tw;
    logic [2:0] lives;
    logic [1:0] ban;
    logic       ra, lu, go, vic;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   errs  = 0;

  // game model
  int m_lvl, m_lw, m_tw, m_lives;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int d, input logic [1:0] b,
                      input logic r, input logic u, input logic g, input logic v);
    exp_t e;
    e.tag = tag; e.d = d;
    e.lvl = 4'(m_lvl); e.lw = 8'(m_lw); e.tw = 8'(m_tw); e.lives = 3'(m_lives);
    e.ban = b; e.ra = r; e.lu = u; e.go = g; e.vic = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    int d;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    d = e.d;
    chk({e.tag, ".level"},  lvl[d],   e.lvl);
    chk({e.tag, ".lwins"},  lw[d],    e.lw);
    chk({e.tag, ".twins"},  tw[d],    e.tw);
    chk({e.tag, ".lives"},  lives[d], e.lives);
    chk({e.tag, ".banner"}, ban[d],   e.ban);
    chk({e.tag, ".active"}, ra[d],    e.ra);
    chk({e.tag, ".lvlup"},  lu[d],    e.lu);
    chk({e.tag, ".over"},   go[d],    e.go);
    chk({e.tag, ".vict"},   vic[d],   e.vic);
  endtask

  // which: 0 start, 1 win, 2 lose, 3 win+lose together
  task automatic pulse(input int d, input int which, input bit cmp);
    @(negedge clk);
    case (which)
      0: start[d] = 1'b1;
      1: win[d]   = 1'b1;
      2: lose[d]  = 1'b1;
      default: begin win[d] = 1'b1; lose[d] = 1'b1; end
    endcase
    @(negedge clk);
    start[d] = 1'b0; win[d] = 1'b0; lose[d] = 1'b0;
    @(posedge clk); #1;
    if (cmp) pop_cmp();
  endtask

  task automatic start_game(input int d, input string tag);
    m_lvl = 1; m_lw = 0; m_tw = 0; m_lives = 3;
    push(tag, d, 2'b00, 1, 0, 0, 0);
    pulse(d, 0, 1);
  endtask

  task automatic ev_win(input int d, input string tag, input int wpl, input int which);
    m_lw++;
    if (m_tw < 255) m_tw++;
    if (m_lw == wpl) begin
      m_lw = 0;
      push(tag, d, 2'b11, 0, 1, 0, 0);
    end else begin
      push(tag, d, 2'b01, 0, 0, 0, 0);
    end
    pulse(d, which, 1);
  endtask

  // Called just after the edge that entered a hold/LEVEL state: the banner
  // must last exactly H cycles, then play resumes.
  task automatic hold_then_play(input int d, input string tag, input bit lvl_adv);
    for (int i = 0; i < H - 1; i++) begin
      @(posedge clk); #1;
      if (i == 0) chk({tag, ".lvlup_off"}, lu[d], 0);
    end
    chk({tag, ".still_hold"}, (ban[d] != 2'b00 && !ra[d]), 1);
    if (lvl_adv) m_lvl++;
    push({tag, ".play"}, d, 2'b00, 1, 0, 0, 0);
    @(posedge clk); #1;
    pop_cmp();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; win[d] = 1'b0; lose[d] = 1'b0;
    end
    m_lvl = 0; m_lw = 0; m_tw = 0; m_lives = 0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_a", 0, 2'b00, 0, 0, 0, 0);
    push("rst_b", 1, 2'b00, 0, 0, 0, 0);
    pop_cmp();
    pop_cmp();
    @(negedge clk) rst_n[0] = 1'b1;

    // 1: start
    start_game(0, "t1_start");

    // 2: five wins -> level up to 2
    for (int w = 0; w < 5; w++) begin
      ev_win(0, "t2_win", 5, 1);
      hold_then_play(0, "t2_hold", (w == 4));
    end

    // start while playing is ignored
    push("start_ign", 0, 2'b00, 1, 0, 0, 0);
    pulse(0, 0, 1);

    // 4: win and lose together -> win only
    ev_win(0, "t4_both", 5, 3);
    hold_then_play(0, "t4_hold", 0);

    // 5: win held high -> one event
    m_lw++; m_tw++;
    push("t5_held", 0, 2'b01, 0, 0, 0, 0);
    @(negedge clk) win[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    pop_cmp();
    repeat (100) @(posedge clk);
    @(negedge clk) win[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push("t5_after_held", 0, 2'b00, 1, 0, 0, 0);
    pop_cmp();
    // pulses during the hold are discarded
    ev_win(0, "t5_pulse", 5, 1);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    repeat (2 * H) @(posedge clk);
    #1;
    push("t5_after_hold", 0, 2'b00, 1, 0, 0, 0);
    pop_cmp();

    // 3: three losses -> game over
    for (int l = 0; l < 3; l++) begin
      m_lives--;
      if (m_lives == 0) begin
        push("t3_over", 0, 2'b00, 0, 0, 1, 0);
        pulse(0, 2, 1);
      end else begin
        push("t3_lose", 0, 2'b10, 0, 0, 0, 0);
        pulse(0, 2, 1);
        hold_then_play(0, "t3_hold", 0);
      end
    end
    // counters frozen in OVER; win ignored
    push("t3_frozen", 0, 2'b00, 0, 0, 1, 0);
    pulse(0, 1, 0);
    repeat (5) @(posedge clk);
    #1;
    pop_cmp();
    start_game(0, "t3_restart");

    // 6: one-level game ending in victory
    @(negedge clk) rst_n[1] = 1'b1;
    start_game(1, "t6_start");
    ev_win(1, "t6_win1", 2, 1);
    hold_then_play(1, "t6_hold", 0);
    ev_win(1, "t6_win2", 2, 1);
    push("t6_victory", 1, 2'b00, 0, 0, 1, 1);
    @(posedge clk); #1;
    pop_cmp();
    start_game(1, "t6_restart");
    ev_win(1, "t6_win3", 2, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n[1] = 1'b0;
    @(posedge clk); #1;
    m_lvl = 0; m_lw = 0; m_tw = 0; m_lives = 0;
    push("t6_midrst", 1, 2'b00, 0, 0, 0, 0);
    pop_cmp();

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
